// File: rtl/divider_arbiter_if.sv
// Requester- and divider-side signal bundle for divider_arbiter.
// slave is the arbiter's view; master is the view of the requesters and divider around it.
interface divider_arbiter_if #(
   parameter int WIDTH   = 30,
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]       req_valid_in;
   logic [WIDTH*NUM_REQ-1:0] req_dividend_in;
   logic [WIDTH*NUM_REQ-1:0] req_divisor_in;
   logic [NUM_REQ-1:0]       req_ready_out;
   logic [NUM_REQ-1:0]       resp_valid_out;
   logic [WIDTH-1:0]         resp_quotient_out;
   logic [WIDTH-1:0]         resp_remainder_out;
   logic                     resp_error_out;
   logic [WIDTH-1:0]         div_dividend_out;
   logic [WIDTH-1:0]         div_divisor_out;
   logic                     div_valid_out;
   logic                     div_busy_in;
   logic                     div_valid_in;
   logic [WIDTH-1:0]         div_quotient_in;
   logic [WIDTH-1:0]         div_remainder_in;
   logic                     div_error_in;

   modport slave (
      input  req_valid_in, req_dividend_in, req_divisor_in,
      input  div_busy_in, div_valid_in, div_quotient_in, div_remainder_in, div_error_in,
      output req_ready_out, resp_valid_out, resp_quotient_out, resp_remainder_out,
      output resp_error_out, div_dividend_out, div_divisor_out, div_valid_out
   );

   modport master (
      output req_valid_in, req_dividend_in, req_divisor_in,
      output div_busy_in, div_valid_in, div_quotient_in, div_remainder_in, div_error_in,
      input  req_ready_out, resp_valid_out, resp_quotient_out, resp_remainder_out,
      input  resp_error_out, div_dividend_out, div_divisor_out, div_valid_out
   );
endinterface

// File: rtl/divider_arbiter.sv
// Round-robin scheduler sharing one sequential divider among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining DIV_ARB_TIMEOUT_EN.
module divider_arbiter #(
   parameter int WIDTH   = 30,
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 64
) (
   input logic              clk_in,
   input logic              rst_n_in,
   divider_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] rr_q, rr_d, win_q, win_d;
   logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
   logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0]   dvd_arr [NUM_REQ];
   logic [WIDTH-1:0]   dvs_arr [NUM_REQ];
   logic               found;
   logic [IDX_W-1:0]   pick, cand;
   logic [NUM_REQ-1:0] ready;
   logic               start;
   logic               timeout;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign dvd_arr[i] = bus.req_dividend_in[i*WIDTH +: WIDTH];
      assign dvs_arr[i] = bus.req_divisor_in[i*WIDTH +: WIDTH];
   end

`ifdef DIV_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counts WAIT cycles; any other state holds it at zero, so it clears on entry.
   assign cnt_d   = (state_q == S_WAIT) ? cnt_q + CNT_W'(1) : '0;
   assign timeout = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) cnt_q <= '0;
      else           cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   // Scan from highest offset down so the nearest requester at/after rr wins.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
         if (bus.req_valid_in[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      win_d   = win_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      err_d   = err_q;
      ready   = '0;
      start   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               ready[pick] = 1'b1;
               win_d       = pick;
               rr_d        = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + IDX_W'(1);
               dvd_d       = dvd_arr[pick];
               dvs_d       = dvs_arr[pick];
               if (dvs_arr[pick] == '0) begin
                  quot_d  = '0;
                  rem_d   = '0;
                  err_d   = 1'b1;
                  state_d = S_RESPOND;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (!bus.div_busy_in) begin
               start   = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.div_valid_in) begin
               quot_d  = bus.div_quotient_in;
               rem_d   = bus.div_remainder_in;
               err_d   = bus.div_error_in;
               state_d = S_RESPOND;
            end else if (timeout) begin
               quot_d  = '0;
               rem_d   = '0;
               err_d   = 1'b1;
               state_d = S_RESPOND;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         win_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         win_q   <= win_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
      end
   end

   // The grant is decoded from live requests, so mask it while reset is held.
   assign bus.req_ready_out      = rst_n_in ? ready : '0;
   assign bus.div_valid_out      = start;
   assign bus.resp_valid_out     = (state_q == S_RESPOND) ? (NUM_REQ'(1) << win_q) : '0;
   assign bus.resp_quotient_out  = quot_q;
   assign bus.resp_remainder_out = rem_q;
   assign bus.resp_error_out     = err_q;
   assign bus.div_dividend_out   = dvd_q;
   assign bus.div_divisor_out    = dvs_q;
endmodule

// File: tb/tb_divider_arbiter.sv
// Scoreboard bench for divider_arbiter: directed requests, a scripted divider model,
// and decoupled grant/response monitors.
module tb_divider_arbiter;
   localparam int W = 30;
   localparam int N = 4;

   typedef struct {
      int         idx;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic       err;
   } resp_t;

   typedef struct {
      logic [W-1:0] dvd;
      logic [W-1:0] dvs;
      logic [W-1:0] q;
      logic [W-1:0] r;
      int           delay;
   } div_t;

   logic clk_in = 1'b0;
   logic rst_n_in;
   always #5 clk_in = ~clk_in;

   divider_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

   divider_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(64)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .bus      (bus.slave)
   );

   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   resp_t exp_resp_q[$];
   div_t  script_q[$];
   int    exp_grant_q[$];
   int    req_cnt[N];
   int    granted[N];
   int    start_cnt  = 0;
   bit    div_active = 1'b0;
   int    last_grant_cyc = 0, last_start_cyc = 0, last_dvin_cyc = 0, last_resp_cyc = 0;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ready"},    32'(bus.req_ready_out), 0);
      check({tag, "_resp_v"},   32'(bus.resp_valid_out), 0);
      check({tag, "_quot"},     32'(bus.resp_quotient_out), 0);
      check({tag, "_rem"},      32'(bus.resp_remainder_out), 0);
      check({tag, "_err"},      32'(bus.resp_error_out), 0);
      check({tag, "_div_dvd"},  32'(bus.div_dividend_out), 0);
      check({tag, "_div_dvs"},  32'(bus.div_divisor_out), 0);
      check({tag, "_div_v"},    32'(bus.div_valid_out), 0);
   endtask

   // Queue one request; dq/dr is what the divider model returns, exp_err selects a 0/0/err response.
   task automatic request(input int idx, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                          input logic [W-1:0] dq, input logic [W-1:0] dr, input int delay,
                          input bit exp_err, input bit want_resp);
      resp_t e;
      div_t  d;
      bus.req_dividend_in[idx*W +: W] = dvd;
      bus.req_divisor_in[idx*W +: W]  = dvs;
      exp_grant_q.push_back(idx);
      if (dvs != '0) begin
         d.dvd = dvd; d.dvs = dvs; d.q = dq; d.r = dr; d.delay = delay;
         script_q.push_back(d);
      end
      if (want_resp) begin
         e.idx = idx;
         e.q   = exp_err ? '0 : dq;
         e.r   = exp_err ? '0 : dr;
         e.err = exp_err;
         exp_resp_q.push_back(e);
      end
      req_cnt[idx]++;
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((exp_resp_q.size() != 0 || script_q.size() != 0 || exp_grant_q.size() != 0 ||
              div_active) && n < budget) begin
         @(posedge clk_in);
         n++;
      end
      if (n >= budget) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got %0d cycles expected < %0d", name, n, budget);
      end
      repeat (3) @(posedge clk_in);
      #1;
   endtask

   // Requesters: hold req_valid until granted as many times as asked; check grant order.
   initial begin : req_driver
      int g;
      logic [N-1:0] m;
      bus.req_valid_in = '0;
      forever begin
         @(negedge clk_in);
         if (bus.req_ready_out != '0) begin
            if (exp_grant_q.size() == 0) begin
               check("grant_unexpected", 32'(bus.req_ready_out), 0);
            end else begin
               g = exp_grant_q.pop_front();
               m = '0;
               m[g] = 1'b1;
               check("grant_sel", 32'(bus.req_ready_out), 32'(m));
               last_grant_cyc = cyc;
            end
            for (int i = 0; i < N; i++) if (bus.req_ready_out[i]) granted[i]++;
         end
         @(posedge clk_in);
         #1;
         for (int i = 0; i < N; i++) bus.req_valid_in[i] = (granted[i] < req_cnt[i]);
      end
   end

   // Divider model: follows the script, checks the operands it is handed.
   initial begin : divider_model
      div_t d;
      bus.div_valid_in     = 1'b0;
      bus.div_quotient_in  = '0;
      bus.div_remainder_in = '0;
      bus.div_error_in     = 1'b0;
      forever begin
         @(negedge clk_in);
         if (bus.div_valid_out) begin
            start_cnt++;
            last_start_cyc = cyc;
            if (script_q.size() == 0) begin
               check("div_start_unexpected", 32'(bus.div_valid_out), 0);
            end else begin
               d = script_q.pop_front();
               div_active = 1'b1;
               check("div_dividend", 32'(bus.div_dividend_out), 32'(d.dvd));
               check("div_divisor", 32'(bus.div_divisor_out), 32'(d.dvs));
               repeat (d.delay) @(posedge clk_in);
               #1;
               bus.div_valid_in     = 1'b1;
               bus.div_quotient_in  = d.q;
               bus.div_remainder_in = d.r;
               last_dvin_cyc = cyc;
               @(posedge clk_in);
               #1;
               bus.div_valid_in = 1'b0;
               div_active       = 1'b0;
            end
         end
      end
   end

   // Response monitor: pops the scoreboard whenever any resp_valid bit is up.
   initial begin : resp_monitor
      resp_t e;
      logic [N-1:0] m;
      forever begin
         @(negedge clk_in);
         if (bus.resp_valid_out != '0) begin
            if (exp_resp_q.size() == 0) begin
               check("resp_unexpected", 32'(bus.resp_valid_out), 0);
            end else begin
               e = exp_resp_q.pop_front();
               m = '0;
               m[e.idx] = 1'b1;
               check("resp_sel",  32'(bus.resp_valid_out), 32'(m));
               check("resp_quot", 32'(bus.resp_quotient_out), 32'(e.q));
               check("resp_rem",  32'(bus.resp_remainder_out), 32'(e.r));
               check("resp_err",  32'(bus.resp_error_out), 32'(e.err));
               last_resp_cyc = cyc;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int s0;
      int g0;
      int n;
      rst_n_in             = 1'b0;
      bus.req_dividend_in  = '0;
      bus.req_divisor_in   = '0;
      bus.div_busy_in      = 1'b0;
      repeat (2) @(negedge clk_in);
      check_idle("reset");
      @(posedge clk_in);
      #1 rst_n_in = 1'b1;
      repeat (2) @(posedge clk_in);
      #1;

      // Contention from rr=0: order 0,1,2,3,0.
      request(0, 10000, 7,   1428, 4,   3, 1'b0, 1'b1);
      request(1, 100,   3,   33,   1,   5, 1'b0, 1'b1);
      request(2, 1000,  9,   111,  1,   1, 1'b0, 1'b1);
      request(3, 65535, 256, 255,  255, 2, 1'b0, 1'b1);
      request(0, 10000, 7,   1428, 4,   4, 1'b0, 1'b1);
      drain("contention", 400);
      check("cont_grants0", granted[0], 2);
      check("cont_grants3", granted[3], 1);

      // Single request with a 30-cycle divider.
      s0 = start_cnt;
      g0 = granted[0];
      request(0, 10000, 7, 1428, 4, 30, 1'b0, 1'b1);
      drain("single", 200);
      check("single_grants", granted[0] - g0, 1);
      check("single_starts", start_cnt - s0, 1);
      check("single_start_lat", last_start_cyc - last_grant_cyc, 1);
      check("single_resp_lat", last_resp_cyc - last_dvin_cyc, 1);

      // Zero divisor bypasses the divider.
      s0 = start_cnt;
      request(2, 5, 0, 0, 0, 0, 1'b1, 1'b1);
      drain("zero", 50);
      check("zero_nostart", start_cnt - s0, 0);
      check("zero_lat", last_resp_cyc - last_grant_cyc, 1);

      // Busy divider for 5 cycles after the grant.
      s0 = start_cnt;
      g0 = granted[3];
      bus.div_busy_in = 1'b1;
      request(3, 1000000, 1000, 1000, 0, 6, 1'b0, 1'b1);
      for (n = 0; n < 50 && granted[3] == g0; n++) @(posedge clk_in);
      check("busy_grant", granted[3] - g0, 1);
      repeat (5) @(posedge clk_in);
      #1 bus.div_busy_in = 1'b0;
      drain("busy", 100);
      check("busy_start_lat", last_start_cyc - last_grant_cyc, 6);
      check("busy_starts", start_cnt - s0, 1);

      // Reset mid-WAIT; the divider answers after reset and must be ignored.
      s0 = start_cnt;
      request(1, 100, 3, 33, 1, 20, 1'b0, 1'b0);
      for (n = 0; n < 50 && start_cnt == s0; n++) @(posedge clk_in);
      check("rst_started", start_cnt - s0, 1);
      repeat (2) @(posedge clk_in);
      #1 rst_n_in = 1'b0;
      @(negedge clk_in);
      check_idle("midrst_a");
      @(negedge clk_in);
      check_idle("midrst_b");
      @(posedge clk_in);
      #1 rst_n_in = 1'b1;
      drain("midrst", 100);

      // rr pointer back at 0: with 0 and 2 pending, 0 goes first.
      request(0, 10000, 7, 1428, 4, 2, 1'b0, 1'b1);
      request(2, 1000,  9, 111,  1, 2, 1'b0, 1'b1);
      drain("rr_after_rst", 200);

`ifdef DIV_ARB_TIMEOUT_EN
      // Silent divider: response 64 cycles after entering WAIT, late result ignored.
      request(1, 50, 5, 10, 0, 100, 1'b1, 1'b1);
      drain("timeout", 300);
      check("timeout_lat", last_resp_cyc - (last_start_cyc + 1), 64);
`endif

      check("grants_left", exp_grant_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
